vram_scanout: RTL and testbench

//   Stage directly downstream of the GPU timing generator. Consumes HSYNC/VSYNC/OE/ADDR,

---
 rtl/vram_scanout.sv | 120 ++++++++++++
 tb/tb_vram_scanout.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_scanout.sv
// rtl/vram_scanout.sv - VRAM scanout stage: owns the VRAM port, delays syncs to match
// read latency, and defers queued CPU writes to blanking cycles.
module vram_scanout #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 8,
  parameter int                RD_LAT      = 1,
  parameter int                FIFO_DEPTH  = 4,
  parameter logic [DATA_W-1:0] BLANK_COLOR = 8'h00,
  parameter logic              SYNC_IDLE   = 1'b1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          HSYNC_IN,
  input  logic                          VSYNC_IN,
  input  logic                          OE_IN,
  input  logic [ADDR_W-1:0]             ADDR_IN,
  input  logic                          WR_VALID,
  output logic                          WR_READY,
  input  logic [ADDR_W-1:0]             WR_ADDR,
  input  logic [DATA_W-1:0]             WR_DATA,
  output logic [ADDR_W-1:0]             MEM_ADDR,
  output logic                          MEM_WE,
  output logic [DATA_W-1:0]             MEM_WDATA,
  input  logic [DATA_W-1:0]             MEM_RDATA,
  output logic                          HSYNC,
  output logic                          VSYNC,
  output logic [DATA_W-1:0]             PIXEL,
  output logic                          PIX_VALID,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              push;
  logic              pop;

  // Stage i carries what was sampled i+1 edges ago; the output register adds the last edge.
  logic [RD_LAT:0]   oe_d;
  logic [RD_LAT:0]   hs_d;
  logic [RD_LAT:0]   vs_d;

  assign WR_READY   = (level != LVL_W'(FIFO_DEPTH));
  assign FIFO_LEVEL = level;
  assign push       = WR_VALID & WR_READY;
  assign pop        = ~OE_IN & (level != '0);

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr[wr_ptr] <= WR_ADDR;
      fifo_data[wr_ptr] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Scanout wins the port outright; writes only drain while OE_IN is low.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      MEM_ADDR  <= '0;
      MEM_WE    <= 1'b0;
      MEM_WDATA <= '0;
    end else if (OE_IN) begin
      MEM_ADDR  <= ADDR_IN;
      MEM_WE    <= 1'b0;
    end else if (pop) begin
      MEM_ADDR  <= fifo_addr[rd_ptr];
      MEM_WDATA <= fifo_data[rd_ptr];
      MEM_WE    <= 1'b1;
    end else begin
      MEM_WE    <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      oe_d <= '0;
      hs_d <= {(RD_LAT+1){SYNC_IDLE}};
      vs_d <= {(RD_LAT+1){SYNC_IDLE}};
    end else begin
      oe_d <= {oe_d[RD_LAT-1:0], OE_IN};
      hs_d <= {hs_d[RD_LAT-1:0], HSYNC_IN};
      vs_d <= {vs_d[RD_LAT-1:0], VSYNC_IN};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      PIXEL     <= BLANK_COLOR;
      PIX_VALID <= 1'b0;
      HSYNC     <= SYNC_IDLE;
      VSYNC     <= SYNC_IDLE;
    end else begin
      PIXEL     <= oe_d[RD_LAT] ? MEM_RDATA : BLANK_COLOR;
      PIX_VALID <= oe_d[RD_LAT];
      HSYNC     <= hs_d[RD_LAT];
      VSYNC     <= vs_d[RD_LAT];
    end
  end

endmodule

// File: tb/tb_vram_scanout.sv
// tb/tb_vram_scanout.sv - bench for vram_scanout: VRAM model, queue-based reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_vram_scanout;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 4;
  localparam int L      = RD_LAT + 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        HSYNC_IN, VSYNC_IN, OE_IN, WR_VALID, WR_READY;
  logic [15:0] ADDR_IN, WR_ADDR, MEM_ADDR;
  logic [7:0]  WR_DATA, MEM_WDATA, MEM_RDATA, PIXEL;
  logic        MEM_WE, HSYNC, VSYNC, PIX_VALID;
  logic [2:0]  FIFO_LEVEL;

  vram_scanout #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH),
    .BLANK_COLOR(8'h00), .SYNC_IDLE(1'b1)
  ) dut (
    .CLK(CLK), .RST(RST), .HSYNC_IN(HSYNC_IN), .VSYNC_IN(VSYNC_IN), .OE_IN(OE_IN),
    .ADDR_IN(ADDR_IN), .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .HSYNC(HSYNC), .VSYNC(VSYNC), .PIXEL(PIXEL),
    .PIX_VALID(PIX_VALID), .FIFO_LEVEL(FIFO_LEVEL)
  );

  always #5 CLK = ~CLK;

  // VRAM with one cycle of read latency
  logic [7:0] ram  [0:65535];
  logic [7:0] gold [0:65535];
  logic [7:0] rd_q = 8'h00;
  logic       force_ff = 1'b0;
  always @(posedge CLK) begin
    if (MEM_WE) ram[MEM_ADDR] <= MEM_WDATA;
    rd_q <= ram[MEM_ADDR];
  end
  assign MEM_RDATA = force_ff ? 8'hFF : rd_q;

  int n_chk  = 0;
  int n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: write queue, output prediction queue, golden VRAM contents
  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  typedef struct packed { logic oe; logic hs; logic vs; logic [7:0] pix; } out_t;
  localparam out_t IDLE = '{oe: 1'b0, hs: 1'b1, vs: 1'b1, pix: 8'h00};
  wr_t         q[$];
  out_t        pipe[$];
  out_t        exp_out = IDLE;
  out_t        smp;
  wr_t         head, nw;
  logic [15:0] exp_addr  = 16'h0;
  logic [7:0]  exp_wdata = 8'h0;
  logic        exp_we    = 1'b0;
  bit          m_push, m_pop;

  always @(posedge CLK) begin
    if (!RST) begin
      q.delete();
      pipe.delete();
      for (int i = 0; i < L - 1; i++) pipe.push_back(IDLE);
      exp_out = IDLE; exp_addr = 16'h0; exp_wdata = 8'h0; exp_we = 1'b0;
    end else begin
      m_push = WR_VALID && (q.size() < DEPTH);
      m_pop  = !OE_IN && (q.size() > 0);
      smp.oe = OE_IN; smp.hs = HSYNC_IN; smp.vs = VSYNC_IN;
      smp.pix = OE_IN ? gold[ADDR_IN] : 8'h00;
      pipe.push_back(smp);
      exp_out = pipe.pop_front();
      exp_we = 1'b0;
      if (OE_IN) exp_addr = ADDR_IN;
      else if (m_pop) begin
        head = q.pop_front();
        exp_addr = head.a; exp_wdata = head.d; exp_we = 1'b1;
        gold[head.a] = head.d;
      end
      if (m_push) begin
        nw.a = WR_ADDR; nw.d = WR_DATA;
        q.push_back(nw);
      end
    end
  end

  logic [23:0] wlog[$];
  always @(negedge CLK) begin
    if (!RST) begin
      check("rst_mem_addr", MEM_ADDR, 0);
      check("rst_mem_we", MEM_WE, 0);
      check("rst_mem_wdata", MEM_WDATA, 0);
      check("rst_pixel", PIXEL, 8'h00);
      check("rst_pix_valid", PIX_VALID, 0);
      check("rst_hsync", HSYNC, 1);
      check("rst_vsync", VSYNC, 1);
      check("rst_level", FIFO_LEVEL, 0);
    end else begin
      if (MEM_WE) wlog.push_back({MEM_ADDR, MEM_WDATA});
      check("mem_addr", MEM_ADDR, exp_addr);
      check("mem_we", MEM_WE, exp_we);
      check("mem_wdata", MEM_WDATA, exp_wdata);
      check("fifo_level", FIFO_LEVEL, q.size());
      check("wr_ready", WR_READY, q.size() != DEPTH);
      check("hsync", HSYNC, exp_out.hs);
      check("vsync", VSYNC, exp_out.vs);
      check("pix_valid", PIX_VALID, exp_out.oe);
      check("pixel", PIXEL, exp_out.pix);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic check_log(input string name, input int n, input logic [15:0] a0,
                           input logic [7:0] d0, input logic [15:0] a1, input logic [7:0] d1,
                           input logic [15:0] a2, input logic [7:0] d2);
    logic [23:0] e [3];
    e[0] = {a0, d0}; e[1] = {a1, d1}; e[2] = {a2, d2};
    check({name, "_count"}, wlog.size(), n);
    for (int i = 0; i < n && i < wlog.size() && i < 3; i++) check(name, wlog[i], e[i]);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      ram[a]  = pat(16'(a));
      gold[a] = pat(16'(a));
    end
    ram[16'h1234]  = 8'hA5;
    gold[16'h1234] = 8'hA5;
    OE_IN = 0; HSYNC_IN = 1; VSYNC_IN = 1; ADDR_IN = 0;
    WR_VALID = 0; WR_ADDR = 0; WR_DATA = 0;
    repeat (3) tick();
    RST = 1;
    tick();

    // Latency: address registered after one edge, pixel after three
    OE_IN = 1; ADDR_IN = 16'h1234;
    tick();
    check("lat_mem_addr", MEM_ADDR, 16'h1234);
    ADDR_IN = 16'h1235;
    tick();
    check("lat_early_valid", PIX_VALID, 0);
    tick();
    check("lat_pixel", PIXEL, 8'hA5);
    check("lat_pix_valid", PIX_VALID, 1);
    tick();
    check("lat_pixel2", PIXEL, 8'h7D);
    OE_IN = 0;
    HSYNC_IN = 0;
    tick(); tick();
    check("hs_not_yet", HSYNC, 1);
    tick();
    check("hs_fall", HSYNC, 0);
    HSYNC_IN = 1;
    repeat (3) tick();

    // Deferral: write queued during visible cycles waits for blanking
    OE_IN = 1; ADDR_IN = 16'h0040;
    WR_VALID = 1; WR_ADDR = 16'h0100; WR_DATA = 8'h3C;
    tick();
    WR_VALID = 0;
    for (int i = 1; i < 10; i++) begin
      ADDR_IN = 16'h0040 + 16'(i);
      tick();
    end
    check("defer_level", FIFO_LEVEL, 1);
    check("defer_we", MEM_WE, 0);
    OE_IN = 0;
    tick();
    check("defer_we_on", MEM_WE, 1);
    check("defer_addr", MEM_ADDR, 16'h0100);
    check("defer_wdata", MEM_WDATA, 8'h3C);
    check("defer_level0", FIFO_LEVEL, 0);
    tick();
    check("defer_we_off", MEM_WE, 0);
    OE_IN = 1; ADDR_IN = 16'h0100;
    tick();
    OE_IN = 0;
    tick(); tick();
    check("defer_readback", PIXEL, 8'h3C);
    tick();

    // Full: four queued, fifth held off until space opens
    wlog.delete();
    OE_IN = 1;
    for (int i = 0; i < 4; i++) begin
      WR_VALID = 1; WR_ADDR = 16'h0300 + 16'(i); WR_DATA = 8'h80 + 8'(i);
      tick();
    end
    WR_ADDR = 16'h0304; WR_DATA = 8'h84;
    check("full_ready", WR_READY, 0);
    check("full_level", FIFO_LEVEL, 4);
    tick(); tick();
    check("full_hold", FIFO_LEVEL, 4);
    OE_IN = 0;
    tick();
    check("full_pop1", FIFO_LEVEL, 3);
    check("full_ready1", WR_READY, 1);
    tick();
    check("full_pop2", FIFO_LEVEL, 3);
    WR_VALID = 0;
    repeat (5) tick();
    check("full_drained", FIFO_LEVEL, 0);
    check("full_count", wlog.size(), 5);
    for (int i = 0; i < 5 && i < wlog.size(); i++)
      check("full_order", wlog[i], {16'h0300 + 16'(i), 8'h80 + 8'(i)});

    // Simultaneous push and pop
    wlog.delete();
    OE_IN = 1;
    WR_VALID = 1; WR_ADDR = 16'h0500; WR_DATA = 8'h21;
    tick();
    WR_ADDR = 16'h0501; WR_DATA = 8'h22;
    tick();
    check("sim_level2", FIFO_LEVEL, 2);
    OE_IN = 0; WR_ADDR = 16'h0200; WR_DATA = 8'h11;
    tick();
    check("sim_level_hold", FIFO_LEVEL, 2);
    WR_VALID = 0;
    repeat (3) tick();
    check_log("sim_order", 3, 16'h0500, 8'h21, 16'h0501, 8'h22, 16'h0200, 8'h11);

    // Blank with forced read data
    force_ff = 1;
    repeat (4) tick();
    check("blank_pixel", PIXEL, 8'h00);
    check("blank_valid", PIX_VALID, 0);
    check("blank_we", MEM_WE, 0);
    force_ff = 0;

    // Mixed scan: visible runs, sync pulses, writes into the scanned region
    for (int i = 0; i < 40; i++) begin
      OE_IN    = (i % 10) < 7;
      ADDR_IN  = 16'h0500 + 16'(i);
      HSYNC_IN = (i % 10) != 8;
      VSYNC_IN = !(i >= 20 && i < 23);
      WR_VALID = (i % 3) == 0;
      WR_ADDR  = 16'h0500 + 16'(i % 8) + 16'(i / 10);
      WR_DATA  = 8'hC0 + 8'(i);
      tick();
    end
    WR_VALID = 0; HSYNC_IN = 1; VSYNC_IN = 1; OE_IN = 0;
    repeat (6) tick();

    // Reset mid-line with two queued writes
    OE_IN = 1; HSYNC_IN = 0; ADDR_IN = 16'h0010;
    WR_VALID = 1; WR_ADDR = 16'h0600; WR_DATA = 8'h01;
    tick();
    WR_ADDR = 16'h0601; WR_DATA = 8'h02;
    tick();
    WR_VALID = 0;
    tick(); tick();
    check("pre_rst_level", FIFO_LEVEL, 2);
    check("pre_rst_valid", PIX_VALID, 1);
    RST = 0;
    #1;
    check("mid_rst_pixel", PIXEL, 8'h00);
    check("mid_rst_valid", PIX_VALID, 0);
    check("mid_rst_hsync", HSYNC, 1);
    check("mid_rst_vsync", VSYNC, 1);
    check("mid_rst_we", MEM_WE, 0);
    check("mid_rst_level", FIFO_LEVEL, 0);
    WR_VALID = 1;
    tick();
    WR_VALID = 0; OE_IN = 0; HSYNC_IN = 1;
    tick();
    wlog.delete();
    RST = 1;
    repeat (5) tick();
    check("post_rst_writes", wlog.size(), 0);
    check("post_rst_level", FIFO_LEVEL, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
